// File: rtl/risc_irq_ctrl.sv
// risc_irq_ctrl: external interrupt controller for the RiSC core.
// Latches rising edges on the device request lines and masks them.
// Presents the lowest-index unmasked pending source to the CPU as an irq
// with a cause vector, then tracks the ack / end-of-interrupt handshake.
module risc_irq_ctrl #(
    parameter int          NSRC  = 8,
    parameter logic [15:0] VBASE = 16'h0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] dev_irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pending,
    output logic            irq,
    output logic [15:0]     vector,
    input  logic            ack,
    input  logic            eoi,
    output logic            in_service,
    output logic [3:0]      cur_src
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] cur_bit;
    logic [NSRC-1:0] clr;
    logic [3:0]      winner;
    logic            any_req;
    logic            take_ack;
    logic            withdraw;

    // Cause vector for a source index; plain 16-bit add that wraps.
    function automatic logic [15:0] calc_vector(input logic [3:0] idx);
        return VBASE + {12'b0, idx};
    endfunction

    // Edge detect, arbitration and the pending-clear decode for the FSM.
    always_comb begin
        rise    = dev_irq & ~prev;
        req     = pending & ~mask;
        cur_bit = {{(NSRC-1){1'b0}}, 1'b1} << cur_src;
        winner  = 4'd0;
        any_req = |req;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = i[3:0];
            end
        end
        // An ack that lands in the same cycle as the mask write still wins:
        // the CPU already saw irq high and has committed to the handler.
        take_ack = (state == ST_REQ) && ack;
        withdraw = (state == ST_REQ) && !ack && |(mask & cur_bit);
        clr      = take_ack ? cur_bit : '0;
    end

    // Edge history, mask register and pending latch; a new edge beats a clear.
    always_ff @(posedge clk) begin
        prev <= dev_irq;
        if (!reset) begin
            mask    <= '1;
            pending <= '0;
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end
            pending <= (pending & ~clr) | rise;
        end
    end

    // Request / service handshake FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            irq        <= 1'b0;
            vector     <= VBASE;
            in_service <= 1'b0;
            cur_src    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_REQ;
                        cur_src <= winner;
                        vector  <= calc_vector(winner);
                        irq     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (take_ack) begin
                        state      <= ST_SERVICE;
                        irq        <= 1'b0;
                        in_service <= 1'b1;
                    end else if (withdraw) begin
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    irq        <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_irq_ctrl.sv
// Directed testbench for risc_irq_ctrl (NSRC=8, VBASE=16'h0010).
module tb_risc_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  dev_irq;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic [7:0]  mask;
    logic [7:0]  pending;
    logic        irq;
    logic [15:0] vector;
    logic        ack;
    logic        eoi;
    logic        in_service;
    logic [3:0]  cur_src;

    int n_tests;
    int n_fail;

    risc_irq_ctrl #(.NSRC(8), .VBASE(16'h0010)) dut (
        .clk        (clk),
        .reset      (reset),
        .dev_irq    (dev_irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .irq        (irq),
        .vector     (vector),
        .ack        (ack),
        .eoi        (eoi),
        .in_service (in_service),
        .cur_src    (cur_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        step();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        dev_irq    = 8'h04;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        ack        = 1'b0;
        eoi        = 1'b0;
        #2;
        step();
        step();

        // reset state
        check("rst_mask", mask, 8'hFF);
        check("rst_pending", pending, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_vector", vector, 16'h0010);
        check("rst_in_service", in_service, 1'b0);
        check("rst_cur_src", cur_src, 4'd0);

        // line held high through reset is not an edge
        reset = 1'b1;
        step();
        write_mask(8'h00);
        check("unmask_mask", mask, 8'h00);
        step();
        step();
        check("held_pending", pending, 8'h00);
        check("held_irq", irq, 1'b0);
        dev_irq = 8'h00;
        step();

        // single source 3
        dev_irq = 8'h08;
        step();
        dev_irq = 8'h00;
        check("s3_pending", pending, 8'h08);
        check("s3_irq_early", irq, 1'b0);
        step();
        check("s3_irq", irq, 1'b1);
        check("s3_vector", vector, 16'h0013);
        check("s3_cur_src", cur_src, 4'd3);
        step();
        check("s3_irq_hold", irq, 1'b1);
        check("s3_vector_hold", vector, 16'h0013);
        pulse_ack();
        check("s3_ack_irq", irq, 1'b0);
        check("s3_ack_insvc", in_service, 1'b1);
        check("s3_ack_pending", pending, 8'h00);
        pulse_eoi();
        check("s3_eoi_insvc", in_service, 1'b0);
        step();
        check("s3_idle_irq", irq, 1'b0);

        // priority: sources 5 and 1 together
        dev_irq = 8'h22;
        step();
        dev_irq = 8'h00;
        check("pr_pending", pending, 8'h22);
        step();
        check("pr_irq1", irq, 1'b1);
        check("pr_vector1", vector, 16'h0011);
        pulse_ack();
        check("pr_pending_after_ack", pending, 8'h20);
        step();
        check("pr_no_nest", irq, 1'b0);
        pulse_eoi();
        check("pr_eoi_irq", irq, 1'b0);
        step();
        check("pr_irq2", irq, 1'b1);
        check("pr_vector2", vector, 16'h0015);
        check("pr_cur_src2", cur_src, 4'd5);
        pulse_ack();
        pulse_eoi();
        check("pr_pending_end", pending, 8'h00);

        // masked pending
        write_mask(8'hFE);
        dev_irq = 8'h10;
        step();
        dev_irq = 8'h00;
        check("mk_pending", pending, 8'h10);
        step();
        step();
        check("mk_irq_masked", irq, 1'b0);
        write_mask(8'h00);
        check("mk_irq_after_write", irq, 1'b0);
        step();
        check("mk_irq", irq, 1'b1);
        check("mk_vector", vector, 16'h0014);
        pulse_ack();
        pulse_eoi();

        // withdrawal of source 0
        dev_irq = 8'h01;
        step();
        dev_irq = 8'h00;
        step();
        check("wd_irq", irq, 1'b1);
        check("wd_vector", vector, 16'h0010);
        write_mask(8'h01);
        step();
        check("wd_irq_drop", irq, 1'b0);
        check("wd_pending_kept", pending, 8'h01);
        step();
        check("wd_stay_idle", irq, 1'b0);

        // collision: new edge on source 0 in the ack cycle
        write_mask(8'h00);
        step();
        check("col_irq", irq, 1'b1);
        dev_irq = 8'h01;
        ack     = 1'b1;
        step();
        dev_irq = 8'h00;
        ack     = 1'b0;
        check("col_pending", pending, 8'h01);
        check("col_insvc", in_service, 1'b1);
        pulse_eoi();
        step();
        check("col_retake_irq", irq, 1'b1);
        check("col_retake_vec", vector, 16'h0010);
        pulse_ack();
        check("col_pending_clr", pending, 8'h00);

        // reset mid-service
        dev_irq = 8'h02;
        step();
        dev_irq = 8'h00;
        check("rs_pending_pre", pending, 8'h02);
        check("rs_insvc_pre", in_service, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rs_insvc", in_service, 1'b0);
        check("rs_irq", irq, 1'b0);
        check("rs_pending", pending, 8'h00);
        check("rs_mask", mask, 8'hFF);
        check("rs_cur_src", cur_src, 4'd0);
        check("rs_vector", vector, 16'h0010);
        pulse_eoi();
        check("rs_eoi_insvc", in_service, 1'b0);
        check("rs_eoi_irq", irq, 1'b0);
        pulse_ack();
        check("rs_ack_insvc", in_service, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_irq_ctrl.md
# risc_irq_ctrl

External interrupt controller that drives the RiSC CPU's interrupt input. It latches rising edges from up to NSRC device request lines, applies a CPU-written mask, and selects the highest-priority pending source. It then raises an interrupt request with a 16-bit cause vector to the CPU. It completes an ack / end-of-interrupt handshake with the CPU's interrupt processor. It is the initiating side of the CPU interrupt interface and sits between the peripherals and the RiSC core in the top-level.

## Interface
- NSRC, 8: number of device request lines; 2..16.
- VBASE, 16'h0010: base of the cause vector; vector = VBASE + source index.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; state is reset on posedge clk while reset==0.
- dev_irq  in  NSRC  device request lines; rising-edge sensitive.
- mask_we  in  1  mask write strobe from CPU control-register path.
- mask_wdata  in  NSRC  new mask value; bit=1 masks the source.
- mask  out  NSRC  current mask register.
- pending  out  NSRC  latched, not-yet-acknowledged edges.
- irq  out  1  interrupt request to CPU.
- vector  out  16  cause vector; valid while irq==1.
- ack  in  1  CPU accepts the request; one-cycle pulse.
- eoi  in  1  CPU finished the handler (return-from-interrupt); one-cycle pulse.
- in_service  out  1  a handler is active.
- cur_src  out  4  index of the source being requested or serviced.

## Operation
- Edge detect: prev register holds dev_irq from the previous cycle. A bit rises when dev_irq & ~prev; that sets pending[i] on the same posedge.
- Priority: the lowest index among (pending & ~mask) wins. Fixed priority; no rotation.
- States:
  - IDLE: if (pending & ~mask) != 0, latch the winner into cur_src and go to REQ.
  - REQ: irq=1, vector=VBASE+cur_src.
    - ack: clear pending[cur_src] and go to SERVICE.
    - mask[cur_src] becomes 1 before ack: withdraw and go to IDLE; pending is kept.
  - SERVICE: in_service=1, irq=0. eoi returns to IDLE.
- No re-arbitration in REQ. A higher-priority edge arriving in REQ or SERVICE stays pending and is taken after eoi.
- No nesting: the controller never raises a new irq while in SERVICE.
- Ignored inputs: ack outside REQ; eoi outside SERVICE.
- Simultaneous set and clear on the same pending bit (a new edge in the ack cycle): set wins, and pending stays 1.
- mask_we updates mask on the next posedge. Masking never clears pending bits.
- vector arithmetic: 16-bit add; wrap-around modulo 2^16.

## Timing
- Reset values:
  - mask = all ones, i.e. all sources masked.
  - pending = 0; irq = 0; vector = VBASE; in_service = 0; cur_src = 0; state = IDLE.
  - prev loads dev_irq, so a line held high through reset is not an edge.
- Reset asserted mid-handshake (REQ or SERVICE) returns to IDLE on that posedge and drops irq. Any later ack/eoi is ignored.
- All outputs are registered.
- Latency:
  - Edge at posedge N (sampled): pending visible after N; state REQ and irq=1 after N+1.
  - ack sampled at posedge M: irq=0, in_service=1 after M.
  - eoi sampled at posedge K: in_service=0 after K. The next irq can rise after K+1.
- vector and cur_src are stable from irq rise until ack is sampled.
- Minimum full cycle (edge → irq → ack → eoi → next irq) is 5 cycles.

## Test plan
- Reset and unmask: hold reset=0 with dev_irq[2]=1, release, then write mask=8'h00 → pending stays 8'h00 and irq stays 0.
- Single source: mask=8'h00; pulse dev_irq[3] at posedge N → pending=8'h08 after N; irq=1 and vector=16'h0013 after N+1; ack → pending=0, in_service=1; eoi → IDLE.
- Priority and ordering: raise dev_irq[5] and dev_irq[1] in the same cycle → first vector=16'h0011. After ack and eoi, the second irq has vector=16'h0015.
- Masked pending: mask=8'hFE; edge on bit 4 → pending=8'h10, irq=0. Write mask=8'h00 → irq=1 two cycles later with vector=16'h0014.
- Withdrawal and collision:
  - In REQ for source 0, write mask=8'h01 → irq drops to 0 and pending[0] stays 1.
  - Separately, a new edge on source 0 in the ack cycle → pending[0]=1 after ack.
- Reset mid-service: reset in SERVICE → in_service=0, irq=0, pending=0, mask=8'hFF. A following eoi pulse has no effect.
